// File: rtl/bram_writer_layer_out.sv
// Streams a latched layer-output vector into BRAM at BASE_ADDR, then optionally
// reads the region back and counts elements that differ from what was written.
module bram_writer_layer_out #(
    parameter int COUNT      = 8,
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int BASE_ADDR  = 0,
    parameter int VERIFY     = 1,
    parameter int RD_LAT     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [COUNT*W-1:0]             data_in,
    output logic                           bram_en,
    output logic                           bram_wen,
    output logic                           bram_ren,
    output logic [ADDR_WIDTH-1:0]          bram_addr,
    output logic [W-1:0]                   bram_din,
    input  logic [W-1:0]                   bram_dout,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(COUNT+1)-1:0]     err_count
);

    localparam int EW = $clog2(COUNT + 1);
    localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [IW-1:0]         LAST = IW'(COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    if (COUNT < 1 || RD_LAT < 1 ||
        longint'(BASE_ADDR) + longint'(COUNT) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_params
        $error("bram_writer_layer_out: COUNT/RD_LAT/BASE_ADDR do not fit ADDR_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, WRITE, READBACK, DONE} state_t;

    state_t              state;
    logic [COUNT*W-1:0]  shadow;
    logic [IW-1:0]       wr_idx;
    logic [IW-1:0]       rd_idx;
    logic [RD_LAT-1:0]   pipe_vld;
    logic [IW-1:0]       pipe_idx [RD_LAT];

    // Read-back tags travel RD_LAT stages so each returning word meets its shadow element.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            pipe_vld  <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_idx[i] <= '0;
            bram_en   <= 1'b0;
            bram_wen  <= 1'b0;
            bram_ren  <= 1'b0;
            bram_addr <= BASE;
            bram_din  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
        end else begin
            pipe_vld[0] <= 1'b0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= WRITE;
                        shadow    <= data_in;
                        wr_idx    <= '0;
                        rd_idx    <= '0;
                        pipe_vld  <= '0;
                        bram_en   <= 1'b1;
                        bram_wen  <= 1'b1;
                        bram_ren  <= 1'b0;
                        bram_addr <= BASE;
                        bram_din  <= data_in[W-1:0];
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err_count <= '0;
                    end
                end

                WRITE: begin
                    if (wr_idx == LAST) begin
                        bram_wen <= 1'b0;
                        if (VERIFY != 0) begin
                            state     <= READBACK;
                            bram_ren  <= 1'b1;
                            bram_addr <= BASE;
                            rd_idx    <= '0;
                        end else begin
                            state   <= DONE;
                            bram_en <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        wr_idx    <= wr_idx + IW'(1);
                        bram_addr <= bram_addr + ADDR_WIDTH'(1);
                        bram_din  <= shadow[(wr_idx + IW'(1)) * W +: W];
                    end
                end

                READBACK: begin
                    if (bram_ren) begin
                        pipe_vld[0] <= 1'b1;
                        pipe_idx[0] <= rd_idx;
                        if (rd_idx == LAST) begin
                            bram_ren <= 1'b0;
                        end else begin
                            rd_idx    <= rd_idx + IW'(1);
                            bram_addr <= bram_addr + ADDR_WIDTH'(1);
                        end
                    end
                    if (pipe_vld[RD_LAT-1]) begin
                        if (bram_dout != shadow[pipe_idx[RD_LAT-1] * W +: W])
                            err_count <= err_count + EW'(1);
                        if (pipe_idx[RD_LAT-1] == LAST) begin
                            state   <= DONE;
                            bram_en <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
